// File: rtl/trace_debugger_stimuli_player.sv
// Trace stimuli player: buffers trace samples in a FIFO and replays them
// onto the core-side trace interface with per-sample idle gaps and stall.
module trace_debugger_stimuli_player #(
  parameter int DEPTH = 16,
  parameter int GAPW  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_valid_i,
  output logic                     load_ready_o,
  input  logic [GAPW-1:0]          load_gap_i,
  input  logic                     load_exception_i,
  input  logic                     load_interrupt_i,
  input  logic [4:0]               load_cause_i,
  input  logic [31:0]              load_tval_i,
  input  logic [2:0]               load_priv_i,
  input  logic [31:0]              load_iaddr_i,
  input  logic [31:0]              load_instr_i,
  input  logic                     load_compressed_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     stall_i,
  output logic                     ivalid_o,
  output logic                     iexception_o,
  output logic                     interrupt_o,
  output logic [4:0]               cause_o,
  output logic [31:0]              tval_o,
  output logic [2:0]               priv_o,
  output logic [31:0]              iaddr_o,
  output logic [31:0]              instr_o,
  output logic                     compressed_o,
  output logic                     busy_o,
  output logic                     underrun_o,
  output logic [15:0]              count_o,
  output logic [$clog2(DEPTH):0]   fill_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        exception;
    logic        interrupt;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [2:0]  priv;
    logic [31:0] iaddr;
    logic [31:0] instr;
    logic        compressed;
  } sample_t;

  typedef struct packed {
    logic [GAPW-1:0] gap;
    sample_t         s;
  } entry_t;

  typedef enum logic {IDLE, RUN} state_t;

  entry_t          mem [DEPTH];
  entry_t          din;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     fill;
  logic [GAPW-1:0] gap_cnt;
  state_t          state;
  sample_t         trace;
  logic            valid;
  logic [15:0]     count;
  logic            underrun;
  logic            push;
  logic            pop;
  logic            empty;
  logic            ripe;

  assign din = '{
    gap: load_gap_i,
    s: '{
      exception:  load_exception_i,
      interrupt:  load_interrupt_i,
      cause:      load_cause_i,
      tval:       load_tval_i,
      priv:       load_priv_i,
      iaddr:      load_iaddr_i,
      instr:      load_instr_i,
      compressed: load_compressed_i
    }
  };

  assign empty        = (fill == '0);
  assign load_ready_o = (fill != FULL);
  assign push         = load_valid_i && load_ready_o;
  assign ripe         = (gap_cnt >= mem[rd_ptr].gap);
  // Pop mirrors the emit branch of the RUN state below
  assign pop = (state == RUN) && !stop_i && !stall_i && !empty && ripe;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: fill <= fill + 1'b1;
        pop && !push: fill <= fill - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      valid    <= 1'b0;
      trace    <= '0;
      count    <= '0;
      underrun <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          valid <= 1'b0;
          trace <= '0;
          if (start_i && !stop_i) begin
            state    <= RUN;
            count    <= '0;
            underrun <= 1'b0;
            gap_cnt  <= '0;
          end
        end
        RUN: begin
          if (stop_i) begin
            state   <= IDLE;
            valid   <= 1'b0;
            trace   <= '0;
            gap_cnt <= '0;
          end else if (!stall_i) begin
            if (empty) begin
              valid    <= 1'b0;
              trace    <= '0;
              underrun <= 1'b1;
            end else if (!ripe) begin
              valid   <= 1'b0;
              trace   <= '0;
              gap_cnt <= gap_cnt + 1'b1;
            end else begin
              valid   <= 1'b1;
              trace   <= mem[rd_ptr].s;
              gap_cnt <= '0;
              count   <= count + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign ivalid_o     = valid;
  assign iexception_o = trace.exception;
  assign interrupt_o  = trace.interrupt;
  assign cause_o      = trace.cause;
  assign tval_o       = trace.tval;
  assign priv_o       = trace.priv;
  assign iaddr_o      = trace.iaddr;
  assign instr_o      = trace.instr;
  assign compressed_o = trace.compressed;
  assign busy_o       = (state == RUN);
  assign underrun_o   = underrun;
  assign count_o      = count;
  assign fill_o       = fill;
endmodule

// File: tb/tb_trace_debugger_stimuli_player.sv
// Bench for the trace stimuli player: directed scenarios plus random
// traffic, every cycle compared against a queue-based reference model.
module tb_trace_debugger_stimuli_player;
  localparam int DEPTH = 16;
  localparam int GAPW  = 4;

  typedef struct packed {
    logic [3:0]  gap;
    logic        exc;
    logic        irq;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [2:0]  priv;
    logic [31:0] iaddr;
    logic [31:0] instr;
    logic        comp;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  smp_t        ld;
  logic        start;
  logic        stop;
  logic        stall;
  logic        ivalid;
  logic        iexception;
  logic        interrupt;
  logic [4:0]  cause;
  logic [31:0] tval;
  logic [2:0]  priv;
  logic [31:0] iaddr;
  logic [31:0] instr;
  logic        compressed;
  logic        busy;
  logic        underrun;
  logic [15:0] count;
  logic [4:0]  fill;

  always #5 clk = ~clk;

  trace_debugger_stimuli_player #(.DEPTH(DEPTH), .GAPW(GAPW)) dut (
    .clk_i(clk), .rst_i(rst),
    .load_valid_i(load_valid), .load_ready_o(load_ready),
    .load_gap_i(ld.gap), .load_exception_i(ld.exc),
    .load_interrupt_i(ld.irq), .load_cause_i(ld.cause),
    .load_tval_i(ld.tval), .load_priv_i(ld.priv),
    .load_iaddr_i(ld.iaddr), .load_instr_i(ld.instr),
    .load_compressed_i(ld.comp),
    .start_i(start), .stop_i(stop), .stall_i(stall),
    .ivalid_o(ivalid), .iexception_o(iexception),
    .interrupt_o(interrupt), .cause_o(cause), .tval_o(tval),
    .priv_o(priv), .iaddr_o(iaddr), .instr_o(instr),
    .compressed_o(compressed), .busy_o(busy),
    .underrun_o(underrun), .count_o(count), .fill_o(fill)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the FIFO is a queue, replay follows the stated rules
  smp_t        q[$];
  bit          m_run;
  bit          m_valid;
  bit          m_und;
  int          m_gap;
  logic [15:0] m_cnt;
  smp_t        m_out;

  function automatic logic [127:0] pk(smp_t s);
    return {21'b0, s.exc, s.irq, s.cause, s.tval, s.priv,
            s.iaddr, s.instr, s.comp};
  endfunction

  function automatic logic [127:0] dut_trace();
    return {21'b0, iexception, interrupt, cause, tval, priv,
            iaddr, instr, compressed};
  endfunction

  function automatic smp_t mk(int gap, logic [31:0] addr);
    smp_t s;
    s.gap   = 4'(gap);
    s.exc   = 1'($urandom);
    s.irq   = 1'($urandom);
    s.cause = 5'($urandom);
    s.tval  = $urandom;
    s.priv  = 3'($urandom);
    s.iaddr = addr;
    s.instr = $urandom;
    s.comp  = 1'($urandom);
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    m_run = 0; m_valid = 0; m_und = 0;
    m_gap = 0; m_cnt = '0; m_out = '0;
  endtask

  task automatic model_step();
    bit   acc;
    smp_t nw;
    acc = load_valid && (q.size() < DEPTH);
    nw  = ld;
    if (!m_run) begin
      m_valid = 0; m_out = '0;
      if (start && !stop) begin
        m_run = 1; m_cnt = '0; m_und = 0; m_gap = 0;
      end
    end else if (stop) begin
      m_run = 0; m_valid = 0; m_out = '0; m_gap = 0;
    end else if (!stall) begin
      if (q.size() == 0) begin
        m_valid = 0; m_out = '0; m_und = 1;
      end else if (m_gap < int'(q[0].gap)) begin
        m_valid = 0; m_out = '0; m_gap++;
      end else begin
        m_out = q.pop_front();
        m_valid = 1; m_gap = 0; m_cnt++;
      end
    end
    if (acc) q.push_back(nw);
  endtask

  task automatic cmp(string t);
    check({t, " ivalid"}, ivalid, m_valid);
    check({t, " trace"}, dut_trace(), pk(m_out));
    check({t, " busy"}, busy, m_run);
    check({t, " underrun"}, underrun, m_und);
    check({t, " count"}, count, m_cnt);
    check({t, " fill"}, fill, q.size());
    check({t, " ready"}, load_ready, q.size() < DEPTH);
  endtask

  task automatic cyc(string t);
    model_step();
    @(posedge clk);
    #1;
    cmp(t);
  endtask

  task automatic check_zero(string t);
    check({t, " ivalid"}, ivalid, 0);
    check({t, " trace"}, dut_trace(), 0);
    check({t, " busy"}, busy, 0);
    check({t, " underrun"}, underrun, 0);
    check({t, " count"}, count, 0);
    check({t, " fill"}, fill, 0);
    check({t, " ready"}, load_ready, 1);
  endtask

  task automatic stop_run(string t);
    stop = 1;
    cyc(t);
    stop = 0;
  endtask

  initial begin
    int zeros;
    logic [31:0] a;
    rst = 1; load_valid = 0; start = 0; stop = 0; stall = 0;
    ld = '0;
    model_reset();
    #12;
    check_zero("reset");
    rst = 0;

    // Three gap-0 samples play back to back, then underrun
    for (int i = 0; i < 3; i++) begin
      ld = mk(0, 32'h1000 + 32'(4 * i));
      load_valid = 1;
      cyc("t1 load");
    end
    load_valid = 0; start = 1;
    cyc("t1 start");
    start = 0;
    repeat (4) cyc("t1 run");
    check("t1 count", count, 3);
    check("t1 underrun", underrun, 1);
    stop_run("t1 stop");

    // A gap of 3 inserts three idle cycles before the sample
    ld = mk(3, 32'h2222_0000);
    load_valid = 1;
    cyc("t2 load");
    load_valid = 0; start = 1;
    cyc("t2 start");
    start = 0;
    zeros = 0;
    for (int i = 0; i < 10; i++) begin
      cyc("t2 run");
      if (ivalid) break;
      zeros++;
    end
    check("t2 idle cycles", zeros, 3);
    check("t2 iaddr", iaddr, 32'h2222_0000);
    stop_run("t2 stop");

    // Stall freezes a valid sample for four cycles
    ld = mk(0, 32'h3333_0000);
    load_valid = 1;
    cyc("t3 load");
    load_valid = 0; start = 1;
    cyc("t3 start");
    start = 0;
    cyc("t3 emit");
    stall = 1;
    repeat (4) begin
      cyc("t3 stall");
      check("t3 held ivalid", ivalid, 1);
      check("t3 held iaddr", iaddr, 32'h3333_0000);
    end
    stall = 0;
    check("t3 count", count, 1);
    cyc("t3 after");
    stop_run("t3 stop");

    // Fill to DEPTH, then pop with simultaneous push
    for (int i = 0; i < DEPTH; i++) begin
      ld = mk(0, 32'h3000 + 32'(4 * i));
      load_valid = 1;
      cyc("t4 load");
    end
    check("t4 full fill", fill, 16);
    check("t4 full ready", load_ready, 0);
    ld = mk(0, 32'h3040);
    start = 1;
    cyc("t4 start");
    start = 0;
    cyc("t4 pop");
    check("t4 ready after pop", load_ready, 1);
    cyc("t4 push+pop");
    check("t4 push+pop fill", fill, 15);
    load_valid = 0;

    // Stop with five entries left, restart resumes at the next one
    for (int i = 0; i < 20 && fill != 5; i++) cyc("t5 run");
    check("t5 reached five", fill, 5);
    stop_run("t5 stop");
    check("t5 stop ivalid", ivalid, 0);
    check("t5 stop fill", fill, 5);
    start = 1;
    cyc("t5 restart");
    start = 0;
    check("t5 restart count", count, 0);
    cyc("t5 resume");
    check("t5 resume iaddr", iaddr, 32'h3030);
    check("t5 resume count", count, 1);
    repeat (6) cyc("t5 drain");
    stop_run("t5 stop2");

    // Asynchronous reset in the middle of a replay
    for (int i = 0; i < 3; i++) begin
      ld = mk(1, $urandom);
      load_valid = 1;
      cyc("t6 load");
    end
    load_valid = 0; start = 1;
    cyc("t6 start");
    start = 0;
    repeat (3) cyc("t6 run");
    #3 rst = 1;
    #1;
    check_zero("t6 async reset");
    model_reset();
    #3 rst = 0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      a = $urandom;
      ld = mk($urandom_range(0, 3), a);
      load_valid = ($urandom_range(0, 99) < 45);
      stall = ($urandom_range(0, 99) < 20);
      start = ($urandom_range(0, 99) < 6);
      stop = ($urandom_range(0, 99) < 2);
      cyc("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
